// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - width constants and FSM state type for the signed divider
package decode_pkg;

  localparam int DIVIDEND_W = 67;
  localparam int DIVISOR_W  = 28;
  localparam int QUOT_W     = 40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/decode_sdiv_step.sv
// rtl/decode_sdiv_step.sv - one combinational restoring shift-subtract step
module decode_sdiv_step #(
  parameter int W = 28
) (
  input  logic [W:0]   prem,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] nrem,
  output logic         qbit
);

  logic [W:0] sub;
  logic       unused_sub_msb;

  // The incoming remainder is below 2*dvs, so a successful subtract always fits in W bits.
  assign sub            = prem - {1'b0, dvs};
  assign qbit           = (prem >= {1'b0, dvs});
  assign nrem           = qbit ? sub[W-1:0] : prem[W-1:0];
  assign unused_sub_msb = sub[W];

endmodule

// File: rtl/decode_sdiv_67s_28s_40.sv
// rtl/decode_sdiv_67s_28s_40.sv - sequential signed divider with saturation and divide-by-zero flag
module decode_sdiv_67s_28s_40
  import decode_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DIVIDEND_W,
  parameter int DIVISOR_WIDTH  = DIVISOR_W,
  parameter int QUOT_WIDTH     = QUOT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic [DIVIDEND_WIDTH-1:0] din0,
  input  logic [DIVISOR_WIDTH-1:0]  din1,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic [QUOT_WIDTH-1:0]     quot,
  output logic [DIVISOR_WIDTH-1:0]  rem,
  output logic                      ovf,
  output logic                      dz
);

  localparam int DW = DIVIDEND_WIDTH;
  localparam int VW = DIVISOR_WIDTH;
  localparam int QW = QUOT_WIDTH;
  localparam int CW = $clog2(DW + 1);

  localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);
  localparam logic [QW-1:0] QMAX      = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0] QMIN      = {1'b1, {(QW-1){1'b0}}};
  localparam logic [DW-1:0] QMAX_MAG  = DW'(QMAX);
  localparam logic [DW-1:0] QMIN_MAG  = DW'(QMIN);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [DW-1:0] acc;
  logic [VW-1:0] prem;
  logic [VW-1:0] dvs;
  logic          sign_a;
  logic          sign_b;

  logic          accept;
  logic          div_zero;
  logic [DW-1:0] a_mag;
  logic [VW-1:0] b_mag;
  logic          step_q;
  logic [VW-1:0] step_rem;
  logic [QW-1:0] fix_quot;
  logic [VW-1:0] fix_rem;
  logic          fix_ovf;

  assign in_rdy   = (state == IDLE);
  assign out_vld  = (state == DONE);
  assign accept   = in_vld & in_rdy & ce;
  assign div_zero = (din1 == '0);
  assign a_mag    = din0[DW-1] ? (~din0 + 1'b1) : din0;
  assign b_mag    = din1[VW-1] ? (~din1 + 1'b1) : din1;

  // acc shifts dividend bits out of the top while quotient bits enter at the bottom.
  decode_sdiv_step #(.W(VW)) u_step (
    .prem ({prem, acc[DW-1]}),
    .dvs  (dvs),
    .nrem (step_rem),
    .qbit (step_q)
  );

  always_comb begin
    fix_quot = acc[QW-1:0];
    fix_ovf  = 1'b0;
    if (sign_a ^ sign_b) begin
      if (acc > QMIN_MAG) begin
        fix_quot = QMIN;
        fix_ovf  = 1'b1;
      end else begin
        fix_quot = ~acc[QW-1:0] + 1'b1;
      end
    end else if (acc > QMAX_MAG) begin
      fix_quot = QMAX;
      fix_ovf  = 1'b1;
    end
    fix_rem = sign_a ? (~prem + 1'b1) : prem;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = div_zero ? DONE : CALC;
      CALC: if (ce && cnt == LAST_STEP) state_nxt = FIX;
      FIX:  if (ce) state_nxt = DONE;
      DONE: if (ce && out_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      prem   <= '0;
      dvs    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      quot   <= '0;
      rem    <= '0;
      ovf    <= 1'b0;
      dz     <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt    <= '0;
            acc    <= a_mag;
            prem   <= '0;
            dvs    <= b_mag;
            sign_a <= din0[DW-1];
            sign_b <= din1[VW-1];
            if (div_zero) begin
              quot <= din0[DW-1] ? QMIN : QMAX;
              rem  <= '0;
              ovf  <= 1'b0;
              dz   <= 1'b1;
            end
          end
        end
        CALC: begin
          acc  <= {acc[DW-2:0], step_q};
          prem <= step_rem;
          cnt  <= cnt + 1'b1;
        end
        FIX: begin
          quot <= fix_quot;
          rem  <= fix_rem;
          ovf  <= fix_ovf;
          dz   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_sdiv_67s_28s_40.sv
// tb/tb_decode_sdiv_67s_28s_40.sv - directed bench with a wide-arithmetic reference model
module tb_decode_sdiv_67s_28s_40;

  localparam logic signed [127:0] QMAX_L = 128'sd549755813887;
  localparam logic signed [127:0] QMIN_L = -128'sd549755813888;
  localparam logic [39:0] QMAX = 40'h7f_ffff_ffff;
  localparam logic [39:0] QMIN = 40'h80_0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        in_vld;
  logic        in_rdy;
  logic [66:0] din0;
  logic [27:0] din1;
  logic        out_vld;
  logic        out_rdy;
  logic [39:0] quot;
  logic [27:0] rem;
  logic        ovf;
  logic        dz;

  int checks = 0;
  int errors = 0;

  logic        exp_armed = 1'b0;
  logic [39:0] exp_q;
  logic [27:0] exp_r;
  logic        exp_ovf;
  logic        exp_dz;

  decode_sdiv_67s_28s_40 dut (
    .clk     (clk),
    .reset   (reset),
    .ce      (ce),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .din0    (din0),
    .din1    (din1),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .quot    (quot),
    .rem     (rem),
    .ovf     (ovf),
    .dz      (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Plain signed arithmetic: '/' truncates toward zero and '%' follows the dividend's sign.
  task automatic model(input logic [66:0] a, input logic [27:0] b,
                       output logic [39:0] q, output logic [27:0] r,
                       output logic o, output logic z);
    logic signed [127:0] sa, sb, sq, sr;
    sa = {{61{a[66]}}, a};
    sb = {{100{b[27]}}, b};
    o = 1'b0;
    z = 1'b0;
    if (b == 28'd0) begin
      z = 1'b1;
      r = 28'd0;
      q = a[66] ? QMIN : QMAX;
    end else begin
      sq = sa / sb;
      sr = sa % sb;
      r  = sr[27:0];
      if (sq > QMAX_L) begin
        q = QMAX;
        o = 1'b1;
      end else if (sq < QMIN_L) begin
        q = QMIN;
        o = 1'b1;
      end else begin
        q = sq[39:0];
      end
    end
  endtask

  always @(negedge clk) begin
    if (exp_armed && out_vld && !reset) begin
      chk("cmp_quot", quot, exp_q);
      chk("cmp_rem", rem, exp_r);
      chk("cmp_ovf", ovf, exp_ovf);
      chk("cmp_dz", dz, exp_dz);
    end
  end

  task automatic run_op(input logic [66:0] a, input logic [27:0] b, input bit pin,
                        input logic [39:0] lq, input logic [27:0] lr, input logic lo, input logic lz,
                        input int stall, input int hold);
    logic [39:0] mq;
    logic [27:0] mr;
    logic        mo, mz;
    logic [39:0] q0;
    logic [27:0] r0;
    int          lat, exp_lat;
    model(a, b, mq, mr, mo, mz);
    if (pin) begin
      chk("model_q", mq, lq);
      chk("model_r", mr, lr);
      chk("model_ovf", mo, lo);
      chk("model_dz", mz, lz);
    end
    exp_q = mq; exp_r = mr; exp_ovf = mo; exp_dz = mz;
    exp_armed = 1'b1;
    exp_lat = (b == 28'd0) ? 1 : 69 + stall;
    @(negedge clk);
    chk("in_rdy_idle", in_rdy, 1'b1);
    din0 = a; din1 = b; in_vld = 1'b1;
    out_rdy = (hold == 0);
    @(posedge clk); #1;
    in_vld = 1'b0;
    lat = 1;
    while (!out_vld && lat < 300) begin
      if (stall > 0 && lat == 30) ce = 1'b0;
      if (stall > 0 && lat == 30 + stall) ce = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("res_quot", quot, mq);
    chk("res_rem", rem, mr);
    chk("res_ovf", ovf, mo);
    chk("res_dz", dz, mz);
    if (hold > 0) begin
      q0 = quot; r0 = rem;
      din0 = ~a; din1 = 28'd3; in_vld = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        chk("hold_vld", out_vld, 1'b1);
        chk("hold_in_rdy", in_rdy, 1'b0);
        chk("hold_quot", quot, q0);
        chk("hold_rem", rem, r0);
      end
      in_vld = 1'b0;
      out_rdy = 1'b1;
    end
    @(posedge clk); #1;
    chk("in_rdy_after", in_rdy, 1'b1);
    chk("out_vld_after", out_vld, 1'b0);
    exp_armed = 1'b0;
  endtask

  task automatic reset_mid_calc();
    bit seen;
    @(negedge clk);
    din0 = 67'd1000; din1 = 28'd7; in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    ce = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_in_rdy", in_rdy, 1'b1);
    chk("rst_out_vld", out_vld, 1'b0);
    chk("rst_quot", quot, 40'd0);
    chk("rst_rem", rem, 28'd0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_dz", dz, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    ce = 1'b1;
    seen = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (out_vld) seen = 1'b1;
    end
    chk("no_vld_after_reset", seen, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; ce = 1'b1; in_vld = 1'b0; out_rdy = 1'b1;
    din0 = '0; din1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_in_rdy", in_rdy, 1'b1);
    chk("init_out_vld", out_vld, 1'b0);
    chk("init_quot", quot, 40'd0);
    chk("init_rem", rem, 28'd0);
    chk("init_ovf", ovf, 1'b0);
    chk("init_dz", dz, 1'b0);
    reset = 1'b0;

    run_op(67'd1000, 28'd7, 1'b1, 40'd142, 28'd6, 1'b0, 1'b0, 0, 0);
    run_op(-67'sd1000, 28'd7, 1'b1, -40'sd142, -28'sd6, 1'b0, 1'b0, 0, 0);
    run_op(67'd1000, -28'sd7, 1'b1, -40'sd142, 28'd6, 1'b0, 1'b0, 0, 0);
    run_op(-67'sd1000, -28'sd7, 1'b1, 40'd142, -28'sd6, 1'b0, 1'b0, 0, 0);
    run_op(67'd5, 28'd0, 1'b1, QMAX, 28'd0, 1'b0, 1'b1, 0, 0);
    run_op(-67'sd5, 28'd0, 1'b1, QMIN, 28'd0, 1'b0, 1'b1, 0, 0);
    run_op(67'h4_0000_0000_0000, 28'd1, 1'b1, QMAX, 28'd0, 1'b1, 1'b0, 0, 0);
    run_op(-67'sh80_0000_0000, 28'd1, 1'b1, QMIN, 28'd0, 1'b0, 1'b0, 0, 0);
    run_op(67'h4_0000_0000_0000_0000, 28'hfff_ffff, 1'b1, QMAX, 28'd0, 1'b1, 1'b0, 0, 0);
    run_op(67'd1000, 28'd7, 1'b1, 40'd142, 28'd6, 1'b0, 1'b0, 0, 10);
    run_op(67'd1000, 28'd7, 1'b1, 40'd142, 28'd6, 1'b0, 1'b0, 5, 0);

    run_op(67'h3_ffff_ffff_ffff_ffff, 28'h800_0000, 1'b0, '0, '0, 1'b0, 1'b0, 0, 0);
    run_op(67'h4_0000_0000_0000_0000, 28'h800_0000, 1'b0, '0, '0, 1'b0, 1'b0, 0, 0);
    run_op(67'd0, 28'd5, 1'b0, '0, '0, 1'b0, 1'b0, 0, 0);
    run_op(67'd123456789012345, -28'sd98765, 1'b0, '0, '0, 1'b0, 1'b0, 0, 0);

    reset_mid_calc();
    run_op(67'd1000, 28'd7, 1'b1, 40'd142, 28'd6, 1'b0, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_sdiv_67s_28s_40.md
DECODE_SDIV_67S_28S_40 -- requirements
Module: decode_sdiv_67s_28s_40

Interface
REQ-001 SHALL have parameter DIVIDEND_WIDTH, default 67, signed dividend width.
REQ-002 SHALL have parameter DIVISOR_WIDTH, default 28, signed divisor width.
REQ-003 SHALL have parameter QUOT_WIDTH, default 40, signed quotient width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port ce  input  1  clock enable; low freezes all state, counters and outputs.
REQ-007 SHALL have port in_vld  input  1  operands valid.
REQ-008 SHALL have port in_rdy  output  1  block can accept operands.
REQ-009 SHALL have port din0  input  DIVIDEND_WIDTH  signed dividend.
REQ-010 SHALL have port din1  input  DIVISOR_WIDTH  signed divisor.
REQ-011 SHALL have port out_vld  output  1  result valid.
REQ-012 SHALL have port out_rdy  input  1  consumer accepts result.
REQ-013 SHALL have port quot  output  QUOT_WIDTH  signed quotient.
REQ-014 SHALL have port rem  output  DIVISOR_WIDTH  signed remainder.
REQ-015 SHALL have port ovf  output  1  quotient saturated.
REQ-016 SHALL have port dz  output  1  divide by zero.

Function
REQ-017 SHALL use FSM states IDLE, CALC, FIX, DONE.
REQ-018 in_rdy SHALL be 1 only in IDLE; accept = in_vld & in_rdy & ce at cycle N.
REQ-019 On accept with din1 != 0, SHALL register operand magnitudes and signs, clear 7-bit iteration counter, go CALC.
REQ-020 CALC SHALL perform one restoring shift-subtract step per ce cycle, 67 steps (cycles N+1..N+67), then go FIX.
REQ-021 FIX SHALL apply signs and saturation in one cycle; out_vld SHALL rise at N+69 (ce held high).
REQ-022 Quotient SHALL truncate toward zero; rem SHALL take the dividend's sign, with |rem| < |din1| and din0 = q*din1 + rem.
REQ-023 Signed quotient outside [-2^39, 2^39-1] SHALL saturate to the nearer bound with ovf=1; -2^39 exactly SHALL give ovf=0.
REQ-024 On accept with din1 == 0, SHALL go directly to DONE; out_vld at N+1; dz=1, rem=0, ovf=0, quot = 2^39-1 if din0 >= 0, else -2^39.
REQ-025 DONE SHALL hold out_vld, quot, rem, ovf and dz stable until out_rdy & ce, then return to IDLE in the next cycle.
REQ-026 Results SHALL not change while out_vld=1 and out_rdy=0; in_vld SHALL be ignored outside IDLE.
REQ-027 ce=0 in any state SHALL stall without loss; latency SHALL extend by the number of stalled cycles.

Reset
REQ-028 reset=1 SHALL immediately force IDLE, in_rdy=1, out_vld=0, quot=0, rem=0, ovf=0, dz=0, counter=0, regardless of ce.
REQ-029 Reset mid-CALC SHALL discard the operation; no out_vld SHALL follow for it.

Structure
REQ-030 Package decode_pkg SHALL hold the width constants and the FSM state enum type.
REQ-031 One sub-module, decode_sdiv_step, SHALL implement one combinational restoring step (partial remainder, divisor -> next remainder, quotient bit).

Verification
REQ-032 1000/7 -> quot=142, rem=6, ovf=0, dz=0, out_vld exactly 69 cycles after accept.
REQ-033 -1000/7 -> quot=-142, rem=-6; 1000/-7 -> quot=-142, rem=6; -1000/-7 -> quot=142, rem=-6.
REQ-034 5/0 -> quot=2^39-1, rem=0, dz=1, out_vld at N+1; -5/0 -> quot=-2^39, dz=1.
REQ-035 2^50/1 -> quot=2^39-1, ovf=1; -2^39/1 -> quot=-2^39, ovf=0; (-2^66)/(-1) -> quot=2^39-1, ovf=1.
REQ-036 out_rdy low 10 cycles in DONE -> outputs and out_vld stable, in_rdy=0; ce low 5 cycles in CALC -> out_vld at N+74.
REQ-037 reset pulse at N+30 -> in_rdy=1 and all outputs 0 immediately; next accepted 1000/7 gives 142/6 with normal latency.
